output_wb_scheduler: RTL and testbench
======================================

OUTPUT_WB_SCHEDULER -- requirements
Module: output_wb_scheduler

Interface
REQ-001 CLK  in  1  single clock; all state updates on its rising edge.
REQ-002 RST  in  1  reset, asynchronous, active-high.
REQ-003 REQ  in  4  per-group writeback request, group g = bit g; held until the matching GNT pulse or withdrawn.
REQ-004 LAST  in  4  per-group last-partial flag, sampled with REQ.
REQ-005 BLOCK  in  1024  per-group 4x4 result tile; group g at [256g+255:256g].
REQ-006 GNT  out  4  one-hot, one-cycle accept pulse.
REQ-007 EN_O  out  1  output SRAM write enable.
REQ-008 ADDR_O  out  4  output SRAM word address.
REQ-009 WDATA_O  out  64  output SRAM write data.
REQ-010 BUSY  out  1  high while a write burst is in progress.
REQ-011 DONE  out  1  one-cycle pulse on the final beat of each burst.

Function
REQ-012 States: IDLE, WRITE; 2-bit beat counter k = 0..3 is valid in WRITE.
REQ-013 Arbitration slot: any cycle in IDLE, or WRITE with k==3.
- In a slot with any REQ bit set, a round-robin pick selects group g.
- Search starts at (last granted + 1) mod 4.
REQ-014 At the slot edge the block:
- latches BLOCK[g] into a 256-bit tile register;
- registers GNT[g]=1 for the next cycle only;
- enters WRITE with k=0.
REQ-015 In WRITE beat k:
- EN_O=1;
- ADDR_O = base(g) + 2k, where base = {0,1,8,9} for g = 0..3;
- WDATA_O = tile[255-64k -: 64].
REQ-016 Latency: REQ seen at slot cycle t gives GNT and beat 0 at t+1, beat 3 at t+4, and DONE at t+4.
REQ-017 Back-to-back: a pick made in the k==3 cycle produces beat 0 of the next burst at t+5, with no idle bubble.
REQ-018 With no pick at k==3, the next state is IDLE, with EN_O=0, BUSY=0, and ADDR_O/WDATA_O holding their last values.
REQ-019 BUSY=1 exactly while state is WRITE.
REQ-020 A REQ bit that drops before grant is ignored.
- GNT is never issued to a group whose REQ is low in the slot.
REQ-021 All four REQ set continuously produces grants in order 0,1,2,3,0, so each group gets one burst per 4 bursts.

Reset
REQ-022 RST=1 forces immediately, regardless of clock:
- state IDLE, k=0, GNT=0, EN_O=0, ADDR_O=0, WDATA_O=0, BUSY=0, DONE=0;
- tile register 0;
- round-robin pointer set so group 0 has highest priority.
REQ-023 Reset mid-burst abandons the remaining beats; no beat is re-issued after release.
REQ-024 The first arbitration slot is the first rising edge after RST falls.

Configuration
REQ-025 Macro OWB_ACCUM_EN:
- When defined, each group owns a 256-bit accumulator ACC[g], reset to 0.
- A grant with LAST[g]=0 sets ACC[g] <= ACC[g] + BLOCK[g], as sixteen independent 16-bit lanes with wrap-around and no carry between lanes.
- That grant issues GNT only: no write beats, and state stays/returns to IDLE; the next slot is the following cycle.
- A grant with LAST[g]=1 loads tile <= ACC[g] + BLOCK[g] (lanewise), clears ACC[g] to 0, and runs a normal 4-beat burst.
REQ-026 Without OWB_ACCUM_EN:
- LAST is ignored and no accumulators exist;
- every grant writes BLOCK[g] directly as in REQ-014/015.

Verification
REQ-027 Single request, group 2, BLOCK[767:512] = 64'hA, 64'hB, 64'hC, 64'hD (MSB first):
- GNT=4'b0100 at t+1;
- writes (8,A), (10,B), (12,C), (14,D) at t+1..t+4;
- DONE at t+4, then IDLE.
REQ-028 REQ=4'b1111 held:
- grants 0,1,2,3,0 every 4 cycles;
- EN_O continuously high;
- addresses 0,2,4,6,1,3,5,7,8,...
REQ-029 RST pulsed during beat 1 of group 1:
- EN_O drops asynchronously and remaining beats are not written;
- the next grant after release with REQ=4'b0011 goes to group 0.
REQ-030 REQ[3] raised then dropped while group 0 bursts:
- no GNT[3] is issued;
- the burst ends in IDLE.
REQ-031 OWB_ACCUM_EN, group 0, lane value 16'hFFFF sent LAST=0, then 16'h0002 with LAST=1:
- first grant writes nothing;
- written lane is 16'h0001, with no carry into the neighbouring lane;
- ACC[0] reads 0 after.
REQ-032 Without OWB_ACCUM_EN, the same stimulus produces two 4-beat bursts, writing 16'hFFFF then 16'h0002.

Source files
------------

// File: rtl/output_wb_scheduler_if.sv
// output_wb_scheduler_if
// Groups the request side and the output SRAM side of the writeback scheduler.
//   req     [3:0]    per-group writeback request (group g = bit g)
//   last    [3:0]    per-group last-partial flag, sampled with req
//   block   [1023:0] per-group 4x4 result tile, group g at [256g+255:256g]
//   gnt     [3:0]    one-hot, one-cycle accept pulse
//   en_o             output SRAM write enable
//   addr_o  [3:0]    output SRAM word address
//   wdata_o [63:0]   output SRAM write data
//   busy             high while a write burst is in progress
//   done             one-cycle pulse on the final beat of each burst
// The master modport is the requester/SRAM side; the slave modport is the scheduler.
interface output_wb_scheduler_if;
    logic [3:0]    req;
    logic [3:0]    last;
    logic [1023:0] block;
    logic [3:0]    gnt;
    logic          en_o;
    logic [3:0]    addr_o;
    logic [63:0]   wdata_o;
    logic          busy;
    logic          done;

    modport master (
        output req, last, block,
        input  gnt, en_o, addr_o, wdata_o, busy, done
    );

    modport slave (
        input  req, last, block,
        output gnt, en_o, addr_o, wdata_o, busy, done
    );
endinterface

// File: rtl/output_wb_scheduler.sv
// output_wb_scheduler
// Round-robin writeback scheduler: picks one of four groups requesting a
// writeback, latches its 256-bit result tile and streams it to the output
// SRAM as four 64-bit beats (MSB word first) at addresses base(g) + 2k,
// base = {0,1,8,9}. A new pick can be made on the last beat so bursts run
// back to back without a bubble.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  output_wb_scheduler_if.slave (req/last/block in; gnt/en_o/addr_o/
//        wdata_o/busy/done out)
// Optional feature, macro OWB_ACCUM_EN: per-group 256-bit accumulators.
// A grant with last=0 only accumulates (lanewise 16-bit wrap-around add) and
// pulses gnt; a grant with last=1 writes acc+block and clears the accumulator.
module output_wb_scheduler (
    input  logic                  clk,
    input  logic                  rst,
    output_wb_scheduler_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [1:0]    grp_q, grp_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [255:0]  tile_q, tile_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          en_q, en_d;
    logic [3:0]    addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          done_q, done_d;

    logic          slot;
    logic          pick_valid;
    logic [1:0]    pick_g;
    logic [1:0]    cand;
    logic [255:0]  pick_block;

`ifdef OWB_ACCUM_EN
    logic [255:0]  acc_q [4];
    logic [255:0]  acc_d [4];
    logic [255:0]  acc_sum;

    // Sixteen independent 16-bit lanes; carries never cross a lane boundary.
    function automatic logic [255:0] lane_add(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            s[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
        end
        return s;
    endfunction
`else
    wire unused_last = ^bus.last;
`endif

    function automatic logic [3:0] base_addr(input logic [1:0] g);
        logic [3:0] b;
        case (g)
            2'd0:    b = 4'd0;
            2'd1:    b = 4'd1;
            2'd2:    b = 4'd8;
            default: b = 4'd9;
        endcase
        return b;
    endfunction

    // An arbitration slot is any IDLE cycle or the final beat of a burst.
    assign slot = (state_q == IDLE) || (k_q == 2'd3);

    // Round-robin search starting one past the last granted group; the last
    // candidate (i == 4 wraps to ptr_q) is the previously granted group.
    always_comb begin
        pick_valid = 1'b0;
        pick_g     = '0;
        cand       = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_g     = cand;
            end
        end
    end

    assign pick_block = bus.block[{pick_g, 8'b0} +: 256];

    // Next-state logic. Output registers are computed from the next state so
    // beat 0 appears in the cycle right after the slot edge; in IDLE the
    // address/data registers simply hold.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        grp_d   = grp_q;
        ptr_d   = ptr_q;
        tile_d  = tile_q;
        gnt_d   = '0;
        en_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
`ifdef OWB_ACCUM_EN
        acc_d   = acc_q;
        acc_sum = '0;
`endif

        if (state_q == WRITE) begin
            if (k_q == 2'd3) begin
                state_d = IDLE;
                k_d     = '0;
            end else begin
                k_d = k_q + 2'd1;
            end
        end

        if (slot && pick_valid) begin
            gnt_d = 4'b0001 << pick_g;
            ptr_d = pick_g;
            grp_d = pick_g;
`ifdef OWB_ACCUM_EN
            acc_sum = lane_add(acc_q[pick_g], pick_block);
            if (bus.last[pick_g]) begin
                tile_d         = acc_sum;
                acc_d[pick_g]  = '0;
                state_d        = WRITE;
                k_d            = '0;
            end else begin
                // Partial result: accumulate only, state falls back to IDLE.
                acc_d[pick_g]  = acc_sum;
            end
`else
            tile_d  = pick_block;
            state_d = WRITE;
            k_d     = '0;
`endif
        end

        if (state_d == WRITE) begin
            en_d    = 1'b1;
            addr_d  = base_addr(grp_d) + {1'b0, k_d, 1'b0};
            // Beat k carries tile[255-64k -: 64]; (3-k) == ~k for 2 bits.
            wdata_d = tile_d[{~k_d, 6'b0} +: 64];
            done_d  = (k_d == 2'd3);
        end
    end

    // State and output registers; reset puts the pointer at 3 so group 0
    // wins the first search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            grp_q   <= '0;
            ptr_q   <= 2'd3;
            tile_q  <= '0;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            grp_q   <= grp_d;
            ptr_q   <= ptr_d;
            tile_q  <= tile_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

`ifdef OWB_ACCUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 4; g++) begin
                acc_q[g] <= '0;
            end
        end else begin
            for (int g = 0; g < 4; g++) begin
                acc_q[g] <= acc_d[g];
            end
        end
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.en_o    = en_q;
    assign bus.addr_o  = addr_q;
    assign bus.wdata_o = wdata_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == WRITE);

endmodule

// File: tb/tb_output_wb_scheduler.sv
// tb_output_wb_scheduler
// Self-checking bench for output_wb_scheduler: a table of per-cycle vectors
// for continuous four-way requesting, hand-written sequences for single
// request, asynchronous reset mid-burst, withdrawn request and partial
// accumulation (OWB_ACCUM_EN aware), then randomized requesting checked
// against a queue-of-beats reference model.
module tb_output_wb_scheduler;

    logic clk;
    logic rst;

    output_wb_scheduler_if bus_if ();

    output_wb_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic        en;
        logic [3:0]  addr;
        logic [63:0] data;
        logic        done;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } beat_t;

    int baseTab [4] = '{0, 1, 8, 9};

    // Drive all request-side inputs at once.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] last,
                                 input logic [1023:0] block);
        bus_if.req   = req;
        bus_if.last  = last;
        bus_if.block = block;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eGnt, input logic eEn,
                            input logic [3:0] eAddr, input logic [63:0] eData,
                            input logic eDone, input logic eBusy);
        checkOutput({tag, ".gnt"},   64'(bus_if.gnt),     64'(eGnt));
        checkOutput({tag, ".en"},    64'(bus_if.en_o),    64'(eEn));
        checkOutput({tag, ".addr"},  64'(bus_if.addr_o),  64'(eAddr));
        checkOutput({tag, ".wdata"}, bus_if.wdata_o,      eData);
        checkOutput({tag, ".done"},  64'(bus_if.done),    64'(eDone));
        checkOutput({tag, ".busy"},  64'(bus_if.busy),    64'(eBusy));
    endtask

    // Pulse reset for one cycle, check the reset state, release on a negedge
    // so the next rising edge is the first arbitration slot.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'h0, 4'h0, '0);
        @(negedge clk);
        checkAll("reset", 4'h0, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        vec_t           vecs [20];
        logic [1023:0]  tblBlock;
        logic [1023:0]  blk;
        logic [63:0]    w;
        beat_t          mq [$];
        int             mPtr;
        logic [3:0]     expGnt;
        logic [3:0]     lastAddr;
        logic [63:0]    lastData;
        logic [3:0]     rq;
        logic [1023:0]  rb;
        logic [255:0]   tile;
        logic           slot;

        rst = 1'b1;
        applyStimulus(4'h0, 4'h0, '0);

        // Table: all four groups requesting continuously; five bursts.
        tblBlock = '0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++)
                tblBlock[g*256 + (3-k)*64 +: 64] = {8'(g + 1), 8'(k), 48'h0000_1234_5678};
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                int g;
                g = b % 4;
                vecs[b*4 + k].req  = 4'hF;
                vecs[b*4 + k].gnt  = (k == 0) ? 4'(1 << g) : 4'h0;
                vecs[b*4 + k].en   = 1'b1;
                vecs[b*4 + k].addr = 4'(baseTab[g] + 2*k);
                vecs[b*4 + k].data = {8'(g + 1), 8'(k), 48'h0000_1234_5678};
                vecs[b*4 + k].done = (k == 3);
            end
        end

        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].req, 4'hF, tblBlock);
            @(negedge clk);
            checkAll($sformatf("rr%0d", i), vecs[i].gnt, vecs[i].en, vecs[i].addr,
                     vecs[i].data, vecs[i].done, 1'b1);
        end

        // Single request from group 2 with words A,B,C,D (MSB first).
        doReset();
        blk = '0;
        blk[767:512] = {64'hA, 64'hB, 64'hC, 64'hD};
        applyStimulus(4'b0100, 4'hF, blk);
        @(negedge clk);
        checkAll("single.b0", 4'b0100, 1'b1, 4'd8, 64'hA, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'hF, blk);
        @(negedge clk);
        checkAll("single.b1", 4'b0000, 1'b1, 4'd10, 64'hB, 1'b0, 1'b1);
        @(negedge clk);
        checkAll("single.b2", 4'b0000, 1'b1, 4'd12, 64'hC, 1'b0, 1'b1);
        @(negedge clk);
        checkAll("single.b3", 4'b0000, 1'b1, 4'd14, 64'hD, 1'b1, 1'b1);
        @(negedge clk);
        checkAll("single.idle", 4'b0000, 1'b0, 4'd14, 64'hD, 1'b0, 1'b0);

        // Asynchronous reset during beat 1 of group 1.
        doReset();
        blk = '0;
        blk[511:256] = {64'h11, 64'h22, 64'h33, 64'h44};
        applyStimulus(4'b0010, 4'hF, blk);
        @(negedge clk);
        checkAll("arst.b0", 4'b0010, 1'b1, 4'd1, 64'h11, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'hF, blk);
        @(negedge clk);
        checkAll("arst.b1", 4'b0000, 1'b1, 4'd3, 64'h22, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 checkAll("arst.async", 4'b0000, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        blk[255:0] = {64'h55, 64'h66, 64'h77, 64'h88};
        applyStimulus(4'b0011, 4'hF, blk);
        rst = 1'b0;
        @(negedge clk);
        checkAll("arst.regrant", 4'b0001, 1'b1, 4'd0, 64'h55, 1'b0, 1'b1);
        applyStimulus(4'b0010, 4'hF, blk);
        @(negedge clk);
        checkAll("arst.g0b1", 4'b0000, 1'b1, 4'd2, 64'h66, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'hF, blk);

        // Group 3 raises then withdraws its request while group 0 bursts.
        doReset();
        blk = '0;
        blk[255:0]    = {64'h1, 64'h2, 64'h3, 64'h4};
        blk[1023:768] = {64'hF1, 64'hF2, 64'hF3, 64'hF4};
        applyStimulus(4'b0001, 4'hF, blk);
        @(negedge clk);
        checkAll("wd.b0", 4'b0001, 1'b1, 4'd0, 64'h1, 1'b0, 1'b1);
        applyStimulus(4'b1000, 4'hF, blk);
        @(negedge clk);
        checkAll("wd.b1", 4'b0000, 1'b1, 4'd2, 64'h2, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'hF, blk);
        @(negedge clk);
        checkAll("wd.b2", 4'b0000, 1'b1, 4'd4, 64'h3, 1'b0, 1'b1);
        @(negedge clk);
        checkAll("wd.b3", 4'b0000, 1'b1, 4'd6, 64'h4, 1'b1, 1'b1);
        @(negedge clk);
        checkAll("wd.idle", 4'b0000, 1'b0, 4'd6, 64'h4, 1'b0, 1'b0);

        // Partial (LAST=0) 16'hFFFF then final (LAST=1) 16'h0002 in lane 0 of
        // group 0, then a final 16'h0005 to show the accumulator was cleared.
        doReset();
        blk = '0;
        blk[15:0] = 16'hFFFF;
        applyStimulus(4'b0001, 4'h0, blk);
        @(negedge clk);
        checkOutput("acc1.gnt", 64'(bus_if.gnt), 64'h1);
        applyStimulus(4'b0000, 4'h0, blk);
`ifdef OWB_ACCUM_EN
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("acc1.noen%0d", k), 64'(bus_if.en_o), 64'h0);
            @(negedge clk);
        end
`else
        repeat (3) @(negedge clk);
        checkAll("acc1.b3", 4'b0000, 1'b1, 4'd6, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1);
        @(negedge clk);
`endif
        blk[15:0] = 16'h0002;
        applyStimulus(4'b0001, 4'h1, blk);
        @(negedge clk);
        checkAll("acc2.b0", 4'b0001, 1'b1, 4'd0, 64'h0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'h1, blk);
        repeat (3) @(negedge clk);
`ifdef OWB_ACCUM_EN
        checkAll("acc2.b3", 4'b0000, 1'b1, 4'd6, 64'h0000_0000_0000_0001, 1'b1, 1'b1);
`else
        checkAll("acc2.b3", 4'b0000, 1'b1, 4'd6, 64'h0000_0000_0000_0002, 1'b1, 1'b1);
`endif
        @(negedge clk);
        blk[15:0] = 16'h0005;
        applyStimulus(4'b0001, 4'h1, blk);
        @(negedge clk);
        applyStimulus(4'b0000, 4'h1, blk);
        repeat (3) @(negedge clk);
        checkAll("acc3.b3", 4'b0000, 1'b1, 4'd6, 64'h0000_0000_0000_0005, 1'b1, 1'b1);

        // Randomized requesters against a queue-of-beats reference model.
        doReset();
        mPtr     = 3;
        expGnt   = 4'h0;
        lastAddr = 4'h0;
        lastData = 64'h0;
        rq       = 4'h0;
        rb       = '0;
        mq.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (mq.size() > 0)
                checkAll($sformatf("rand%0d", cyc), expGnt, 1'b1, mq[0].addr, mq[0].data,
                         mq.size() == 1, 1'b1);
            else
                checkAll($sformatf("rand%0d", cyc), expGnt, 1'b0, lastAddr, lastData,
                         1'b0, 1'b0);

            for (int g = 0; g < 4; g++) begin
                if (bus_if.gnt[g]) begin
                    rq[g] = 1'b0;
                end else if (!rq[g] && $urandom_range(3) == 0) begin
                    rq[g] = 1'b1;
                    for (int wi = 0; wi < 8; wi++) rb[g*256 + wi*32 +: 32] = $urandom;
                end else if (rq[g] && $urandom_range(15) == 0) begin
                    rq[g] = 1'b0;
                end
            end
            applyStimulus(rq, 4'hF, rb);

            slot = (mq.size() <= 1);
            if (mq.size() > 0) void'(mq.pop_front());
            expGnt = 4'h0;
            if (slot && rq != 4'h0) begin
                int pg;
                pg = -1;
                for (int i = 1; i <= 4; i++)
                    if (pg < 0 && rq[(mPtr + i) % 4]) pg = (mPtr + i) % 4;
                tile = rb[pg*256 +: 256];
                for (int k = 0; k < 4; k++) begin
                    beat_t bt;
                    bt.addr = 4'(baseTab[pg] + 2*k);
                    w = tile[(3-k)*64 +: 64];
                    bt.data = w;
                    mq.push_back(bt);
                end
                mPtr   = pg;
                expGnt = 4'(1 << pg);
            end
            if (mq.size() > 0) begin
                lastAddr = mq[0].addr;
                lastData = mq[0].data;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
